// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped IO hub.
//   IO_TAG     : value addr[31:10] must hold for an access to be IO
//   OFF_*      : register byte offsets inside the IO window (addr[9:0])
//   TCMP_RST   : reset value of the timer compare register
//   reg_sel_e  : decoded register selector
//   decode_addr: maps a full CPU byte address to a register selector
package mmio_pkg;

  localparam logic [21:0] IO_TAG    = '1;
  localparam logic [9:0]  OFF_LED   = 10'h060;
  localparam logic [9:0]  OFF_SW    = 10'h070;
  localparam logic [9:0]  OFF_TCNT  = 10'h080;
  localparam logic [9:0]  OFF_TCMP  = 10'h084;
  localparam logic [9:0]  OFF_TSTAT = 10'h088;
  localparam logic [31:0] TCMP_RST  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_SW,
    SEL_TCNT,
    SEL_TCMP,
    SEL_TSTAT
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr[31:10] == IO_TAG) begin
      case (addr[9:0])
        OFF_LED:   sel = SEL_LED;
        OFF_SW:    sel = SEL_SW;
        OFF_TCNT:  sel = SEL_TCNT;
        OFF_TCMP:  sel = SEL_TCMP;
        OFF_TSTAT: sel = SEL_TSTAT;
        default:   sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser for raw switches, optionally followed
// by a debouncer.
// Build option: MMIO_DEBOUNCE_EN -- when defined, a synchronised vector is
// accepted only after DB_CYCLES consecutive cycles of the same value; when
// undefined the synchronised vector is passed straight through.
// Ports:
//   clock : system clock (rising edge)
//   rst   : synchronous active-high reset
//   sw_i  : raw asynchronous switch inputs [SW_W]
//   sw_o  : accepted switch vector [SW_W]
module sw_debounce
  import mmio_pkg::*;
#(
  parameter int unsigned SW_W      = 16,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic            clock,
  input  logic            rst,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] sw_o
);

  if (DB_CYCLES == 0) begin : g_bad_db
    $error("sw_debounce: DB_CYCLES must be at least 1");
  end

  logic [SW_W-1:0] sync1_q;
  logic [SW_W-1:0] sync2_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int unsigned     CW     = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   DB_MAX = CW'(DB_CYCLES);

  logic [SW_W-1:0] cand_q, cand_d;
  logic [SW_W-1:0] stable_q, stable_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // cnt_q = number of consecutive cycles cand_q has been observed; it
  // saturates at DB_MAX, the cycle on which cand_q becomes the accepted value.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CW'(1);
      if (DB_CYCLES == 1) stable_d = sync2_q;
    end else if (cnt_q != DB_MAX) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == DB_MAX) stable_d = cand_q;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sw_o = stable_q;
`else
  assign sw_o = sync2_q;
`endif

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: CPU memory-mapped IO block with an LED register, a switch input
// register, and a free-running timer with compare interrupt.
// Build option: MMIO_DEBOUNCE_EN (see sw_debounce) enables switch debouncing.
// Ports:
//   clock   : system clock (rising edge)
//   rst     : synchronous active-high reset
//   addr_i  : CPU byte address [32]
//   wdata_i : store data [32]
//   rd_i    : IO read strobe
//   wr_i    : IO write strobe
//   rdata_o : registered read data [32], holds while rd_i is low
//   sw_i    : raw asynchronous switches [SW_W]
//   led_o   : LED register [LED_W]
//   irq_o   : timer match interrupt, level (sticky status bit)
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 16,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic             rd_i,
  input  logic             wr_i,
  output logic [31:0]      rdata_o,
  input  logic [SW_W-1:0]  sw_i,
  output logic [LED_W-1:0] led_o,
  output logic             irq_o
);

  reg_sel_e         sel;
  logic [SW_W-1:0]  sw_acc;
  logic [31:0]      rd_val;
  logic             tstat_clr;

  logic [LED_W-1:0] led_q,   led_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      tcnt_q,  tcnt_d;
  logic [31:0]      tcmp_q,  tcmp_d;
  logic             tstat_q, tstat_d;

  assign sel = decode_addr(addr_i);

  sw_debounce #(
    .SW_W      (SW_W),
    .DB_CYCLES (DB_CYCLES)
  ) u_sw_debounce (
    .clock (clock),
    .rst   (rst),
    .sw_i  (sw_i),
    .sw_o  (sw_acc)
  );

  // Reads sample the current register values, so a simultaneous write to
  // the same register returns the pre-write contents.
  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_LED:   rd_val = 32'(led_q);
      SEL_SW:    rd_val = 32'(sw_acc);
      SEL_TCNT:  rd_val = tcnt_q;
      SEL_TCMP:  rd_val = tcmp_q;
      SEL_TSTAT: rd_val = {31'b0, tstat_q};
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    led_d     = led_q;
    rdata_d   = rd_i ? rd_val : rdata_q;
    tcnt_d    = tcnt_q + 32'd1;
    tcmp_d    = tcmp_q;
    tstat_clr = 1'b0;
    if (wr_i) begin
      case (sel)
        SEL_LED:   led_d     = wdata_i[LED_W-1:0];
        SEL_TCNT:  tcnt_d    = wdata_i;
        SEL_TCMP:  tcmp_d    = wdata_i;
        SEL_TSTAT: tstat_clr = wdata_i[0];
        default:   ;
      endcase
    end
    // Match set has priority over a software clear in the same cycle.
    tstat_d = (tcnt_q == tcmp_q) | (tstat_q & ~tstat_clr);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      led_q   <= '0;
      rdata_q <= '0;
      tcnt_q  <= '0;
      tcmp_q  <= TCMP_RST;
      tstat_q <= 1'b0;
    end else begin
      led_q   <= led_d;
      rdata_q <= rdata_d;
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tstat_q <= tstat_d;
    end
  end

  assign led_o   = led_q;
  assign rdata_o = rdata_q;
  assign irq_o   = tstat_q;

endmodule

// File: tb/tb_mmio_hub.sv
// tb_mmio_hub: self-checking bench for mmio_hub with a behavioural
// reference model (register image plus a history of switch samples).
// Honours MMIO_DEBOUNCE_EN the same way the design does.
module tb_mmio_hub;

  localparam int unsigned LED_W     = 16;
  localparam int unsigned SW_W      = 16;
  localparam int unsigned DB_CYCLES = 4;
`ifdef MMIO_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  localparam logic [31:0] A_LED   = 32'hFFFF_FC60;
  localparam logic [31:0] A_SW    = 32'hFFFF_FC70;
  localparam logic [31:0] A_TCNT  = 32'hFFFF_FC80;
  localparam logic [31:0] A_TCMP  = 32'hFFFF_FC84;
  localparam logic [31:0] A_TSTAT = 32'hFFFF_FC88;
  localparam logic [31:0] A_HOLE  = 32'hFFFF_FC7C;
  localparam logic [31:0] A_NOIO  = 32'h0000_0060;

  logic             clock;
  logic             rst;
  logic [31:0]      addr_i;
  logic [31:0]      wdata_i;
  logic             rd_i;
  logic             wr_i;
  logic [31:0]      rdata_o;
  logic [SW_W-1:0]  sw_i;
  logic [LED_W-1:0] led_o;
  logic             irq_o;

  int unsigned vectors;
  int unsigned errors;

  // Reference model state
  logic [LED_W-1:0] m_led;
  logic [31:0]      m_rdata;
  logic [31:0]      m_tcnt;
  logic [31:0]      m_tcmp;
  logic             m_tstat;
  logic [SW_W-1:0]  m_sw_acc;
  logic [SW_W-1:0]  hist[$];  // hist[0] = sw_i at the most recent edge

  mmio_hub #(
    .LED_W     (LED_W),
    .SW_W      (SW_W),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rd_i    (rd_i),
    .wr_i    (wr_i),
    .rdata_o (rdata_o),
    .sw_i    (sw_i),
    .led_o   (led_o),
    .irq_o   (irq_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Switch value visible to a read: without debouncing it is sw_i from two
  // edges ago; with debouncing it is the last vector that held steady.
  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:10] != 22'h3F_FFFF) return 32'd0;
    case (a[9:0])
      10'h060: return 32'(m_led);
      10'h070: return DEB ? 32'(m_sw_acc) : 32'(hist[1]);
      10'h080: return m_tcnt;
      10'h084: return m_tcmp;
      10'h088: return {31'd0, m_tstat};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] rv;
    logic [31:0] nt;
    logic        set;
    logic        clr;
    logic        all_eq;
    if (rst) begin
      m_led = '0; m_rdata = '0; m_tcnt = '0; m_tcmp = 32'hFFFF_FFFF;
      m_tstat = 1'b0; m_sw_acc = '0;
      hist.delete();
      for (int i = 0; i < int'(DB_CYCLES) + 2; i++) hist.push_back('0);
      return;
    end
    rv  = model_read(addr_i);
    nt  = m_tcnt + 32'd1;
    set = (m_tcnt == m_tcmp);
    clr = 1'b0;
    if (rd_i) m_rdata = rv;
    if (wr_i && addr_i[31:10] == 22'h3F_FFFF) begin
      case (addr_i[9:0])
        10'h060: m_led  = wdata_i[LED_W-1:0];
        10'h080: nt     = wdata_i;
        10'h084: m_tcmp = wdata_i;
        10'h088: clr    = wdata_i[0];
        default: ;
      endcase
    end
    m_tcnt  = nt;
    m_tstat = set | (m_tstat & ~clr);
    all_eq = 1'b1;
    for (int i = 1; i <= int'(DB_CYCLES); i++)
      if (hist[i] !== hist[1]) all_eq = 1'b0;
    if (all_eq) m_sw_acc = hist[1];
    hist.push_front(sw_i);
    void'(hist.pop_back());
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic w);
    addr_i = a; wdata_i = d; rd_i = r; wr_i = w;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_i = '0;
    drive(A_LED, 32'hFFFF_FFFF, 1'b1, 1'b1);
    step(); step();
    vectors++; if (led_o !== '0) begin errors++; $display("FAIL reset.led got %h want 0", led_o); end
    vectors++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL reset.rdata got %h want 0", rdata_o); end
    vectors++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset.irq got %b want 0", irq_o); end
    rst = 1'b0;
    drive(A_TCMP, 0, 1'b1, 1'b0); step();
    vectors++; if (rdata_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset.tcmp got %h want ffffffff", rdata_o); end
    drive(A_TCNT, 0, 1'b1, 1'b0); step();
    vectors++; if (rdata_o !== m_rdata) begin errors++; $display("FAIL reset.tcnt got %h want %h", rdata_o, m_rdata); end
  endtask

  task automatic test_led();
    drive(A_LED, 32'h0000_A5A5, 1'b0, 1'b1); step();
    vectors++; if (led_o !== 16'hA5A5) begin errors++; $display("FAIL led.write got %h want a5a5", led_o); end
    drive(A_LED, 0, 1'b1, 1'b0); step();
    vectors++; if (rdata_o !== 32'h0000_A5A5) begin errors++; $display("FAIL led.readback got %h want 0000a5a5", rdata_o); end
    drive(A_LED, 0, 1'b0, 1'b0); step();
    vectors++; if (rdata_o !== 32'h0000_A5A5) begin errors++; $display("FAIL led.hold got %h want 0000a5a5", rdata_o); end
  endtask

  task automatic test_unmapped();
    drive(A_NOIO, 0, 1'b1, 1'b0); step();
    vectors++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL unmapped.noio_rd got %h want 0", rdata_o); end
    drive(A_LED, 0, 1'b1, 1'b0); step();
    drive(A_HOLE, 0, 1'b1, 1'b0); step();
    vectors++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL unmapped.hole_rd got %h want 0", rdata_o); end
    drive(A_NOIO, 32'h1234, 1'b0, 1'b1); step();
    drive(A_HOLE, 32'h5678, 1'b0, 1'b1); step();
    drive(32'hFFFF_F860, 32'h9ABC, 1'b0, 1'b1); step();
    vectors++; if (led_o !== 16'hA5A5) begin errors++; $display("FAIL unmapped.led got %h want a5a5", led_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    drive(A_LED, 32'h0000_1357, 1'b1, 1'b1); step();
    vectors++; if (rdata_o !== 32'h0000_A5A5) begin errors++; $display("FAIL b2b.led_prewrite got %h want 0000a5a5", rdata_o); end
    vectors++; if (led_o !== 16'h1357) begin errors++; $display("FAIL b2b.led_new got %h want 1357", led_o); end
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      drive(A_TCMP, v, 1'b1, 1'b1); step();
      vectors++; if (rdata_o !== m_rdata) begin errors++; $display("FAIL b2b.tcmp%0d got %h want %h", i, rdata_o, m_rdata); end
    end
    drive(A_TCMP, 0, 1'b1, 1'b0); step();
    vectors++; if (rdata_o !== v) begin errors++; $display("FAIL b2b.tcmp_last got %h want %h", rdata_o, v); end
  endtask

  task automatic test_timer();
    logic [6:0] exp_irq;
    exp_irq = 7'b0110000;  // bit i = irq expected after the i-th cycle
    drive(A_TCMP, 32'h1, 1'b0, 1'b1); step();
    drive(A_TSTAT, 32'h1, 1'b0, 1'b1); step();
    drive(A_TCNT, 32'hFFFF_FFFE, 1'b0, 1'b1); step();
    for (int i = 1; i <= 6; i++) begin
      case (i)
        2, 3:    drive(A_TCNT, 0, 1'b1, 1'b0);
        4, 6:    drive(A_TSTAT, 32'h1, 1'b0, 1'b1);
        default: drive(A_SW, 0, 1'b0, 1'b0);
      endcase
      step();
      vectors++; if (irq_o !== exp_irq[i]) begin errors++; $display("FAIL timer.irq%0d got %b want %b", i, irq_o, exp_irq[i]); end
      vectors++; if (irq_o !== m_tstat) begin errors++; $display("FAIL timer.model%0d got %b want %b", i, irq_o, m_tstat); end
      if (i == 2) begin
        vectors++; if (rdata_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer.tcnt_max got %h want ffffffff", rdata_o); end
      end
      if (i == 3) begin
        vectors++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL timer.wrap got %h want 0", rdata_o); end
      end
    end
  endtask

  task automatic test_switch();
    int first_one;
    int want_first;
    want_first = DEB ? int'(DB_CYCLES) + 2 : 2;
    first_one = -1;
    drive(A_SW, 0, 1'b1, 1'b0);
    sw_i = '0;
    for (int i = 0; i < 10; i++) step();
    for (int i = 0; i < 4; i++) begin
      sw_i = (i < 2) ? 16'h0001 : 16'h0000;
      step();
      vectors++; if (rdata_o !== m_rdata) begin errors++; $display("FAIL switch.glitch%0d got %h want %h", i, rdata_o, m_rdata); end
    end
    sw_i = 16'h0001;
    for (int i = 0; i < 12; i++) begin
      step();
      if (first_one < 0 && rdata_o == 32'h1) first_one = i;
      vectors++; if (rdata_o !== m_rdata) begin errors++; $display("FAIL switch.stable%0d got %h want %h", i, rdata_o, m_rdata); end
    end
    vectors++; if (first_one != want_first) begin errors++; $display("FAIL switch.latency got %0d want %0d", first_one, want_first); end
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    pool = '{A_LED, A_SW, A_TCNT, A_TCMP, A_TSTAT, A_HOLE, A_NOIO, 32'hFFFF_F880};
    for (int i = 0; i < 300; i++) begin
      addr_i  = pool[$urandom_range(0, 7)];
      rd_i    = $urandom_range(0, 1) == 1;
      wr_i    = $urandom_range(0, 2) == 0;
      wdata_i = (addr_i == A_TCMP) ? m_tcnt + $urandom_range(1, 8) : $urandom;
      if ($urandom_range(0, 7) == 0) sw_i = SW_W'($urandom);
      step();
      vectors++; if (rdata_o !== m_rdata) begin errors++; $display("FAIL rand.rdata%0d got %h want %h", i, rdata_o, m_rdata); end
      vectors++; if (led_o !== m_led) begin errors++; $display("FAIL rand.led%0d got %h want %h", i, led_o, m_led); end
      vectors++; if (irq_o !== m_tstat) begin errors++; $display("FAIL rand.irq%0d got %b want %b", i, irq_o, m_tstat); end
    end
  endtask

  task automatic test_reset_midcount();
    int waited;
    drive(A_LED, 32'h0000_FFFF, 1'b0, 1'b1); step();
    drive(A_TSTAT, 32'h1, 1'b0, 1'b1); step();
    drive(A_TCMP, m_tcnt + 32'd4, 1'b0, 1'b1); step();
    drive(A_SW, 0, 1'b0, 1'b0);
    waited = 0;
    while (irq_o !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    vectors++; if (irq_o !== 1'b1) begin errors++; $display("FAIL midrst.irq_timeout got %b want 1", irq_o); end
    vectors++; if (led_o !== 16'hFFFF) begin errors++; $display("FAIL midrst.led_pre got %h want ffff", led_o); end
    rst = 1'b1;
    drive(A_LED, 32'h0000_1234, 1'b1, 1'b1); step();
    vectors++; if (led_o !== '0) begin errors++; $display("FAIL midrst.led got %h want 0", led_o); end
    vectors++; if (irq_o !== 1'b0) begin errors++; $display("FAIL midrst.irq got %b want 0", irq_o); end
    vectors++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL midrst.rdata got %h want 0", rdata_o); end
    rst = 1'b0;
    drive(A_TCMP, 0, 1'b1, 1'b0); step();
    vectors++; if (rdata_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midrst.tcmp got %h want ffffffff", rdata_o); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    sw_i    = '0;
    drive(0, 0, 1'b0, 1'b0);
    test_reset();
    test_led();
    test_unmapped();
    test_back_to_back();
    test_timer();
    test_switch();
    test_random();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 SHALL have parameter LED_W, default 16: LED register width, 1..32.
REQ-002 SHALL have parameter SW_W, default 16: switch input width, 1..32.
REQ-003 SHALL have parameter DB_CYCLES, default 4: stable cycles needed to accept a switch change, at least 1.
REQ-004 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port addr_i  input  32  byte address from the CPU.
REQ-007 SHALL have port wdata_i  input  32  store data.
REQ-008 SHALL have port rd_i  input  1  IO read strobe.
REQ-009 SHALL have port wr_i  input  1  IO write strobe.
REQ-010 SHALL have port rdata_o  output  32  registered read data.
REQ-011 SHALL have port sw_i  input  SW_W  raw asynchronous switches.
REQ-012 SHALL have port led_o  output  LED_W  LED register.
REQ-013 SHALL have port irq_o  output  1  timer match interrupt, level.

Function
REQ-014 SHALL decode an access as IO only when addr_i[31:10] is all ones; offsets are addr_i[9:0]: 0x060 LED, 0x070 SW, 0x080 TCNT, 0x084 TCMP, 0x088 TSTAT.
REQ-015 SHALL complete a write with wr_i high at the same rising edge; LED takes wdata_i[LED_W-1:0].
REQ-016 SHALL present read data on rdata_o one cycle after rd_i; rdata_o holds its value while rd_i is low; data is zero-extended.
REQ-017 SHALL return 0 for reads of unmapped or non-IO addresses and ignore writes to them.
REQ-018 SHALL, when rd_i and wr_i are both high to the same register, return the pre-write value.
REQ-019 SHALL pass sw_i through a 2-flop synchroniser before any other use.
REQ-020 SHALL increment TCNT by 1 every cycle and wrap from 0xFFFFFFFF to 0; a TCNT write loads wdata_i instead of incrementing that cycle.
REQ-021 SHALL set TSTAT[0] (sticky) in the cycle after TCNT equals TCMP; irq_o equals TSTAT[0].
REQ-022 SHALL clear TSTAT[0] on a write with wdata_i[0]=1; a simultaneous set wins.
REQ-023 SHALL read TSTAT as {31'b0, TSTAT[0]}.

Reset
REQ-024 SHALL, while rst is high at an edge, clear led_o, rdata_o, TCNT, TSTAT, synchroniser flops and debounce state to 0, set TCMP to 0xFFFFFFFF, and ignore rd_i and wr_i.
REQ-025 SHALL give reset priority over any in-flight access or debounce count; the accepted switch value restarts at 0.

Configuration
REQ-026 SHALL honour macro MMIO_DEBOUNCE_EN: when defined, a synchronised switch vector is accepted only after DB_CYCLES consecutive cycles of the same value; any change restarts the count.
REQ-027 SHALL, when MMIO_DEBOUNCE_EN is undefined, accept the synchronised vector directly (2-cycle latency) and ignore DB_CYCLES.

Structure
REQ-028 SHALL take the region tag, register offsets and the TCMP reset value from a shared package mmio_pkg.
REQ-029 SHALL place synchroniser plus debounce in one sub-module sw_debounce, parameterised by SW_W and DB_CYCLES.

Verification
REQ-030 SHALL cover this case: write 0x0000A5A5 to 0xFFFFFC60 -> led_o=0xA5A5 next cycle; read back returns 0x0000A5A5 one cycle after rd_i.
REQ-031 SHALL cover this case: read 0x00000060 (non-IO) and 0xFFFFFC7C (unmapped) -> rdata_o=0; led_o unchanged.
REQ-032 SHALL cover this case, with MMIO_DEBOUNCE_EN and DB_CYCLES=4: sw_i 0->0x0001 with a 2-cycle glitch, then stable -> SW reads 0x0001 only after 2+4 stable cycles; the glitch is never visible.
REQ-033 SHALL cover this case: TCNT=0xFFFFFFFE, TCMP=0x00000001 -> wraps to 0, irq_o rises the cycle after TCNT=1; writing TSTAT=1 on the set cycle leaves irq_o=1.
REQ-034 SHALL cover this case: assert rst mid-count with irq_o=1 and led_o=0xFFFF -> next cycle all outputs 0, TCMP reads 0xFFFFFFFF.
